// File: rtl/imem_loader.sv
// Byte-stream program loader: parses a count-prefixed, checksummed byte stream
// into 32-bit instruction-memory writes and holds the CPU in reset until it succeeds.
module imem_loader #(
    parameter int          MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        load_error
);

    typedef enum logic [2:0] {
        IDLE, CNT_HI, CNT_LO, DATA, CHECK, DONE, ERROR
    } state_t;

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t      state, state_nxt;
    logic [15:0] word_total;
    logic [15:0] word_cnt;
    logic [1:0]  byte_cnt;
    logic [23:0] asm_reg;   // the 4th byte completes the word straight into imem_wdata
    logic [7:0]  csum;

    logic        accept;
    logic        start;
    logic [15:0] n_rx;
    logic        last_word;

    assign accept    = byte_valid && byte_ready;
    assign start     = load_start && (state == IDLE || state == DONE || state == ERROR);
    assign n_rx      = {word_total[15:8], byte_data};
    assign last_word = (word_cnt == word_total - 16'd1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERROR: if (load_start) state_nxt = CNT_HI;
            CNT_HI:            if (accept) state_nxt = CNT_LO;
            CNT_LO: begin
                if (accept) begin
                    if (n_rx == 16'd0)             state_nxt = CHECK;
                    else if ({1'b0, n_rx} > MAX_W) state_nxt = ERROR;
                    else                           state_nxt = DATA;
                end
            end
            DATA:    if (accept && byte_cnt == 2'd3 && last_word) state_nxt = CHECK;
            CHECK:   if (accept) state_nxt = (byte_data == csum) ? DONE : ERROR;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        cpu_reset  = 1'b1;
        load_done  = 1'b0;
        load_error = 1'b0;
        case (state)
            CNT_HI, CNT_LO, DATA, CHECK: byte_ready = 1'b1;
            DONE: begin
                cpu_reset = 1'b0;
                load_done = 1'b1;
            end
            ERROR:   load_error = 1'b1;
            default: ;
        endcase
    end

    // Datapath: counters, checksum, word assembly and the write port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word_total <= '0;
            word_cnt   <= '0;
            byte_cnt   <= '0;
            asm_reg    <= '0;
            csum       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            if (start) begin
                word_cnt <= '0;
                byte_cnt <= '0;
                csum     <= '0;
            end else if (accept) begin
                case (state)
                    CNT_HI: begin
                        word_total[15:8] <= byte_data;
                        csum             <= csum ^ byte_data;
                    end
                    CNT_LO: begin
                        word_total[7:0] <= byte_data;
                        csum            <= csum ^ byte_data;
                    end
                    DATA: begin
                        csum     <= csum ^ byte_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        asm_reg  <= {asm_reg[15:0], byte_data};
                        if (byte_cnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= {asm_reg, byte_data};
                            imem_addr  <= BASE_ADDR + {14'd0, word_cnt, 2'b00};
                            word_cnt   <= word_cnt + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal loads, empty program, oversize count,
// stalled stream, mid-session reset and load_start handling.
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        load_done;
    logic        load_error;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        wr_q[$];
    int         we_runs = 0;
    logic       prev_we = 1'b0;
    logic [7:0] seq[$];

    always #5 clock = ~clock;

    imem_loader #(.MAX_WORDS(256), .BASE_ADDR(32'h0000_0000)) dut (
        .clock      (clock),
        .reset      (reset),
        .load_start (load_start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .load_error (load_error)
    );

    // Write monitor; counts any imem_we lasting more than one cycle.
    always @(negedge clock) begin
        if (imem_we) wr_q.push_back('{imem_addr, imem_wdata});
        if (imem_we && prev_we) we_runs++;
        prev_we = imem_we;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [31:0] addr,
                            input logic [31:0] data);
        if (idx < wr_q.size()) begin
            check({tag, "_addr"}, wr_q[idx].addr, addr);
            check({tag, "_data"}, wr_q[idx].data, data);
        end else begin
            check({tag, "_present"}, 32'(wr_q.size()), 32'(idx + 1));
        end
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge clock);
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        while (!byte_ready && t < 20) begin
            @(negedge clock);
            t++;
        end
        if (!byte_ready) begin
            check("ready_timeout", {31'd0, byte_ready}, 32'd1);
            return;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clock);
        byte_valid = 1'b0;
        byte_data  = 8'hA5;
    endtask

    task automatic send_seq(input int max_gap);
        foreach (seq[i]) begin
            if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) begin
                    byte_data = 8'($urandom);
                    @(negedge clock);
                end
            end
            send_byte(seq[i]);
        end
    endtask

    task automatic check_three_words(input string tag);
        check({tag, "_count"}, 32'(wr_q.size()), 32'd3);
        check_wr({tag, "_w0"}, 0, 32'h0, 32'h1122_3344);
        check_wr({tag, "_w1"}, 1, 32'h4, 32'h5566_7788);
        check_wr({tag, "_w2"}, 2, 32'h8, 32'h99AA_BBCC);
        check({tag, "_done"}, {31'd0, load_done}, 32'd1);
        check({tag, "_we_single"}, 32'(we_runs), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        load_start = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (2) @(negedge clock);

        check("rst_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_we",    {31'd0, imem_we},    32'd0);
        check("rst_addr",  imem_addr,           32'h0);
        check("rst_wdata", imem_wdata,          32'h0);
        check("rst_cpu",   {31'd0, cpu_reset},  32'd1);
        check("rst_done",  {31'd0, load_done},  32'd0);
        check("rst_err",   {31'd0, load_error}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_ready", {31'd0, byte_ready}, 32'd0);

        // Two-word program; checksum is the XOR of the ten stream bytes = 0E.
        pulse_start();
        check("t1_ready", {31'd0, byte_ready}, 32'd1);
        seq = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h06};
        send_seq(0);
        check("t1_we_pulse", {31'd0, imem_we}, 32'd1);
        check("t1_we_data",  imem_wdata,       32'h2008_0006);
        send_byte(8'h20);
        check("t1_we_low",   {31'd0, imem_we}, 32'd0);
        seq = '{8'h09, 8'h00, 8'h0B, 8'h0E};
        send_seq(0);
        check("t1_done",  {31'd0, load_done},  32'd1);
        check("t1_cpu",   {31'd0, cpu_reset},  32'd0);
        check("t1_ready_off", {31'd0, byte_ready}, 32'd0);
        check("t1_count", 32'(wr_q.size()),    32'd2);
        check_wr("t1_w0", 0, 32'h0, 32'h2008_0006);
        check_wr("t1_w1", 1, 32'h4, 32'h2009_000B);

        // Same program with checksum 07 must be rejected.
        wr_q.delete();
        pulse_start();
        check("t1b_cpu_restart", {31'd0, cpu_reset}, 32'd1);
        seq = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h06, 8'h20, 8'h09, 8'h00, 8'h0B, 8'h07};
        send_seq(0);
        check("t1b_err", {31'd0, load_error}, 32'd1);
        check("t1b_cpu", {31'd0, cpu_reset},  32'd1);

        // Empty program: good and bad checksum.
        wr_q.delete();
        pulse_start();
        seq = '{8'h00, 8'h00, 8'h00};
        send_seq(0);
        check("t2_done",   {31'd0, load_done}, 32'd1);
        check("t2_nowr",   32'(wr_q.size()),   32'd0);
        pulse_start();
        check("t2b_cpu_restart", {31'd0, cpu_reset}, 32'd1);
        check("t2b_done_clr",    {31'd0, load_done}, 32'd0);
        seq = '{8'h00, 8'h00, 8'h01};
        send_seq(0);
        check("t2b_err", {31'd0, load_error}, 32'd1);
        check("t2b_cpu", {31'd0, cpu_reset},  32'd1);

        // Oversize count 0x0101.
        pulse_start();
        seq = '{8'h01, 8'h01};
        send_seq(0);
        check("t3_err",   {31'd0, load_error}, 32'd1);
        check("t3_ready", {31'd0, byte_ready}, 32'd0);
        check("t3_nowr",  32'(wr_q.size()),    32'd0);

        // Count exactly MAX_WORDS is accepted.
        pulse_start();
        seq = '{8'h01, 8'h00};
        send_seq(0);
        check("max_ready", {31'd0, byte_ready}, 32'd1);
        check("max_err",   {31'd0, load_error}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Three words, gap-free then with random valid gaps; checksum CF.
        wr_q.delete();
        we_runs = 0;
        pulse_start();
        seq = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hCF};
        send_seq(0);
        check_three_words("t4a");
        wr_q.delete();
        pulse_start();
        send_seq(3);
        check_three_words("t4b");

        // Reset after six data bytes of a two-word load.
        wr_q.delete();
        pulse_start();
        seq = '{8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        send_seq(0);
        #2 reset = 1'b1;
        #1;
        check("t5_ready", {31'd0, byte_ready}, 32'd0);
        check("t5_we",    {31'd0, imem_we},    32'd0);
        check("t5_addr",  imem_addr,           32'h0);
        check("t5_wdata", imem_wdata,          32'h0);
        check("t5_cpu",   {31'd0, cpu_reset},  32'd1);
        check("t5_done",  {31'd0, load_done},  32'd0);
        check("t5_err",   {31'd0, load_error}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        byte_valid = 1'b1;
        repeat (4) @(negedge clock);
        byte_valid = 1'b0;
        check("t5_count", 32'(wr_q.size()), 32'd1);
        check_wr("t5_w0", 0, 32'h0, 32'hAABB_CCDD);

        // load_start inside DATA is ignored; checksum 09.
        wr_q.delete();
        pulse_start();
        seq = '{8'h00, 8'h01, 8'h12, 8'h34};
        send_seq(0);
        pulse_start();
        check("t6_ignore_ready", {31'd0, byte_ready}, 32'd1);
        seq = '{8'h56, 8'h78, 8'h09};
        send_seq(0);
        check("t6_done", {31'd0, load_done}, 32'd1);
        check_wr("t6_w0", 0, 32'h0, 32'h1234_5678);

        // Restart from DONE overwrites from the base address; checksum 23.
        wr_q.delete();
        pulse_start();
        seq = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23};
        send_seq(0);
        check("t6b_done",  {31'd0, load_done}, 32'd1);
        check("t6b_count", 32'(wr_q.size()),   32'd1);
        check_wr("t6b_w0", 0, 32'h0, 32'hDEAD_BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
